// File: rtl/hdmi_cfg_sequencer.sv
// Power-up register-table walker: fetches {reg,data} entries from a synchronous ROM and
// issues one I2C byte write per entry, with inline delays, end marker and NACK retry/backoff.
module hdmi_cfg_sequencer #(
  parameter logic [6:0] DEV_ADDR       = 7'h39,
  parameter int         ROM_AW         = 5,
  parameter int         TABLE_LEN      = 32,
  parameter int         MAX_RETRY      = 3,
  parameter int         PWRUP_CYCLES   = 27000,
  parameter int         BACKOFF_CYCLES = 2700
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [6:0]        cmd_dev,
  output logic [7:0]        cmd_reg,
  output logic [7:0]        cmd_data,
  input  logic              rsp_valid,
  input  logic              rsp_nack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ROM_AW-1:0] err_index
);

  localparam int DLY_MAX = 255 * 256;
  localparam int WAIT_MAX = (PWRUP_CYCLES > BACKOFF_CYCLES) ? PWRUP_CYCLES : BACKOFF_CYCLES;
  localparam int CNT_MAX  = (WAIT_MAX > DLY_MAX) ? WAIT_MAX : DLY_MAX;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int RW       = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0]     PWRUP_LD   = CW'(PWRUP_CYCLES - 1);
  localparam logic [CW-1:0]     BACKOFF_LD = CW'(BACKOFF_CYCLES - 1);
  localparam logic [ROM_AW-1:0] LAST_IDX   = ROM_AW'(TABLE_LEN - 1);
  localparam logic [RW-1:0]     RETRY_MAX  = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_FETCH, S_DECODE, S_ISSUE,
    S_WAIT_RSP, S_DELAY, S_BACKOFF, S_DONE, S_FAIL
  } state_t;

  state_t            state;
  state_t            next;
  logic [CW-1:0]     cnt;
  logic [ROM_AW-1:0] idx;
  logic [RW-1:0]     retry;
  logic              last;
  logic              is_end;
  logic              is_delay;

  assign last     = (idx == LAST_IDX);
  assign is_end   = (rom_data[15:8] == 8'hFE);
  assign is_delay = (rom_data[15:8] == 8'hFF);
  assign rom_addr = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE:     next = S_PWRUP;
      S_PWRUP:    if (cnt == '0) next = S_FETCH;
      S_FETCH:    next = S_DECODE;
      S_DECODE: begin
        if (is_end)        next = S_DONE;
        else if (is_delay) next = S_DELAY;
        else               next = S_ISSUE;
      end
      S_ISSUE:    if (cmd_ready) next = S_WAIT_RSP;
      S_WAIT_RSP: begin
        if (rsp_valid) begin
          if (!rsp_nack)              next = last ? S_DONE : S_FETCH;
          else if (retry < RETRY_MAX) next = S_BACKOFF;
          else                        next = S_FAIL;
        end
      end
      S_BACKOFF:  if (cnt == '0) next = S_ISSUE;
      S_DELAY:    if (cnt == '0) next = last ? S_DONE : S_FETCH;
      S_DONE,
      S_FAIL:     if (start) next = S_FETCH;
      default:    next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = (state == S_ISSUE);
    busy      = !(state == S_IDLE || state == S_DONE || state == S_FAIL);
    done      = (state == S_DONE);
    error     = (state == S_FAIL);
  end

  // One shared down-counter serves power-up, backoff and delay: each phase lasts load+1 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      retry     <= '0;
      cmd_dev   <= '0;
      cmd_reg   <= '0;
      cmd_data  <= '0;
      err_index <= '0;
    end else begin
      case (state)
        S_IDLE:  cnt <= PWRUP_LD;
        S_PWRUP, S_BACKOFF: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        S_DECODE: begin
          if (is_delay) begin
            cnt <= CW'({rom_data[7:0], 8'h00});
          end else if (!is_end) begin
            cmd_dev  <= DEV_ADDR;
            cmd_reg  <= rom_data[15:8];
            cmd_data <= rom_data[7:0];
            retry    <= '0;
          end
        end
        S_WAIT_RSP: begin
          if (rsp_valid) begin
            if (!rsp_nack) begin
              if (!last) idx <= idx + ROM_AW'(1);
            end else if (retry < RETRY_MAX) begin
              retry <= retry + RW'(1);
              cnt   <= BACKOFF_LD;
            end else begin
              err_index <= idx;
            end
          end
        end
        S_DELAY: begin
          if (cnt != '0)  cnt <= cnt - CW'(1);
          else if (!last) idx <= idx + ROM_AW'(1);
        end
        S_DONE, S_FAIL: begin
          if (start) begin
            idx       <= '0;
            err_index <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// Directed bench: ROM model plus a simple I2C engine model with programmable ready stall,
// fixed response latency and per-register NACK counts.
module tb_hdmi_cfg_sequencer;

  localparam int P   = 20;
  localparam int B   = 10;
  localparam int LAT = 3;

  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [4:0]  rom_addr;
  logic [15:0] rom_data;
  logic        cmd_valid, cmd_ready;
  logic [6:0]  cmd_dev;
  logic [7:0]  cmd_reg, cmd_data;
  logic        rsp_valid, rsp_nack;
  logic        busy, done, error;
  logic [4:0]  err_index;

  int tests = 0;
  int fails = 0;

  logic [15:0] rom [32];
  int          nack_left [256];
  int          stall_cfg = 0;
  int          stall_cnt;
  int          pend;
  logic        stray_req = 0;
  logic [7:0]  cur_reg;
  logic [7:0]  log_reg[$];
  logic [7:0]  log_data[$];
  logic [6:0]  log_dev[$];

  hdmi_cfg_sequencer #(
    .DEV_ADDR(7'h39), .ROM_AW(5), .TABLE_LEN(8), .MAX_RETRY(3),
    .PWRUP_CYCLES(P), .BACKOFF_CYCLES(B)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
    .busy(busy), .done(done), .error(error), .err_index(err_index)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  // Engine model: acts on negedges so everything it drives is settled by the next posedge.
  initial begin
    cmd_ready = 0; rsp_valid = 0; rsp_nack = 0; pend = 0; stall_cnt = 0; cur_reg = 0;
    for (int i = 0; i < 256; i++) nack_left[i] = 0;
    forever begin
      @(negedge clk);
      rsp_valid = 0;
      rsp_nack  = 0;
      if (rst) begin
        pend = 0; cmd_ready = 0; stall_cnt = stall_cfg;
      end else begin
        if (stray_req) begin rsp_valid = 1; stray_req = 0; end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            rsp_valid = 1;
            if (nack_left[cur_reg] > 0) begin rsp_nack = 1; nack_left[cur_reg]--; end
          end
        end
        if (!cmd_valid) begin
          cmd_ready = 0; stall_cnt = stall_cfg;
        end else if (stall_cnt > 0) begin
          cmd_ready = 0; stall_cnt--;
        end else begin
          cmd_ready = 1;
          log_reg.push_back(cmd_reg); log_data.push_back(cmd_data); log_dev.push_back(cmd_dev);
          cur_reg = cmd_reg;
          pend = LAT;
        end
      end
    end
  end

  // sel: 0 = cmd_valid, 1 = done, 2 = error. n = negedges waited, -1 on timeout.
  task automatic wait_sig(input int sel, input int limit, output int n);
    logic hit;
    n = 0; hit = 0;
    while (!hit && n < limit) begin
      @(negedge clk);
      n++;
      hit = (sel == 0) ? cmd_valid : (sel == 1) ? done : error;
    end
    if (!hit) n = -1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = 16'hFE00;
    log_reg.delete(); log_data.delete(); log_dev.delete();
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic test_reset();
    int n;
    clear_rom();
    rom[0] = 16'h1234; rom[1] = 16'h5678; rom[2] = 16'hFE00;
    rst = 1;
    repeat (3) @(negedge clk);
    tests++;
    if ({rom_addr, cmd_valid, cmd_dev, cmd_reg, cmd_data, busy, done, error, err_index} !== '0) begin
      fails++; $display("FAIL reset_outputs: got busy=%0b valid=%0b reg=%h expected all zero", busy, cmd_valid, cmd_reg);
    end
    rst = 0;
    wait_sig(0, 200, n);
    tests++;
    if (n !== P + 3) begin fails++; $display("FAIL pwrup_latency: got %0d expected %0d", n, P + 3); end
    tests++;
    if (cmd_dev !== 7'h39 || cmd_reg !== 8'h12 || cmd_data !== 8'h34 || rom_addr !== 5'd0) begin
      fails++; $display("FAIL first_payload: got %h/%h/%h expected 39/12/34", cmd_dev, cmd_reg, cmd_data);
    end
    wait_sig(0, 200, n);
    tests++;
    if (n !== 6 || cmd_reg !== 8'h56 || cmd_data !== 8'h78 || rom_addr !== 5'd1) begin
      fails++; $display("FAIL second_cmd: got n=%0d reg=%h data=%h expected 6/56/78", n, cmd_reg, cmd_data);
    end
    wait_sig(1, 200, n);
    tests++;
    if (n !== 6 || busy !== 1'b0 || error !== 1'b0) begin
      fails++; $display("FAIL done_timing: got n=%0d busy=%0b expected 6/0", n, busy);
    end
    tests++;
    if (log_reg.size() !== 2 || log_dev[0] !== 7'h39 || log_reg[1] !== 8'h56) begin
      fails++; $display("FAIL cmd_log: got %0d commands expected 2", log_reg.size());
    end
  endtask

  task automatic test_ready_stall();
    int n;
    logic bad;
    clear_rom();
    rom[0] = 16'h2001; rom[1] = 16'h2102; rom[2] = 16'hFE00;
    stall_cfg = 10;
    pulse_start();
    wait_sig(0, 50, n);
    tests++;
    if (n !== 2) begin fails++; $display("FAIL restart_latency: got %0d expected 2", n); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!cmd_valid || cmd_dev !== 7'h39 || cmd_reg !== 8'h20 || cmd_data !== 8'h01) bad = 1;
    end
    @(negedge clk);
    tests++;
    if (bad || cmd_valid !== 1'b0) begin
      fails++; $display("FAIL stall_hold: got unstable=%0b valid_after=%0b expected 0/0", bad, cmd_valid);
    end
    wait_sig(1, 200, n);
    tests++;
    if (n < 0 || log_reg.size() !== 2 || log_reg[0] !== 8'h20 || log_data[1] !== 8'h02) begin
      fails++; $display("FAIL stall_accepts: got %0d commands n=%0d expected 2", log_reg.size(), n);
    end
    stall_cfg = 0;
  endtask

  task automatic test_nack_retry();
    int n0, n1, n2, n3, n4, nd;
    clear_rom();
    rom[0] = 16'h3001; rom[1] = 16'h3102; rom[2] = 16'h3203; rom[3] = 16'hFE00;
    nack_left[8'h32] = 2;
    pulse_start();
    wait_sig(0, 50, n0); wait_sig(0, 50, n1); wait_sig(0, 50, n2);
    wait_sig(0, 50, n3); wait_sig(0, 50, n4); wait_sig(1, 50, nd);
    tests++;
    if (n2 !== 6 || n3 !== B + 4 || n4 !== B + 4) begin
      fails++; $display("FAIL backoff_gap: got %0d/%0d expected %0d/%0d", n3, n4, B + 4, B + 4);
    end
    tests++;
    if (nd !== 6 || error !== 1'b0 || log_reg.size() !== 5 || log_reg[4] !== 8'h32 || log_data[3] !== 8'h03) begin
      fails++; $display("FAIL retry_done: got nd=%0d cmds=%0d expected 6/5", nd, log_reg.size());
    end
  endtask

  task automatic test_nack_fail();
    int n;
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = {8'h40 + 8'(i), 8'h10 + 8'(i)};
    rom[5] = 16'hFE00;
    nack_left[8'h44] = 4;
    pulse_start();
    wait_sig(2, 300, n);
    tests++;
    if (n !== 72 || err_index !== 5'd4 || done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL nack_exhaust: got n=%0d idx=%0d done=%0b busy=%0b expected 72/4/0/0", n, err_index, done, busy);
    end
    wait_sig(0, 40, n);
    tests++;
    if (n !== -1 || log_reg.size() !== 8 || error !== 1'b1) begin
      fails++; $display("FAIL fail_quiet: got n=%0d cmds=%0d expected -1/8", n, log_reg.size());
    end
    pulse_start();
    wait_sig(0, 50, n);
    tests++;
    if (n !== 2 || cmd_reg !== 8'h40 || rom_addr !== 5'd0 || error !== 1'b0 || err_index !== 5'd0) begin
      fails++; $display("FAIL fail_restart: got n=%0d reg=%h err=%0b expected 2/40/0", n, cmd_reg, error);
    end
    wait_sig(1, 200, n);
    tests++;
    if (n !== 30) begin fails++; $display("FAIL rerun_done: got %0d expected 30", n); end
  endtask

  task automatic test_delay();
    int n;
    clear_rom();
    rom[0] = 16'h5001; rom[1] = 16'hFF02; rom[2] = 16'h5102;
    rom[3] = 16'hFF00; rom[4] = 16'h5203; rom[5] = 16'hFE00;
    pulse_start();
    wait_sig(0, 50, n);
    wait_sig(0, 1000, n);
    tests++;
    if (n !== 9 + 512 || cmd_reg !== 8'h51 || rom_addr !== 5'd2) begin
      fails++; $display("FAIL delay_512: got %0d reg=%h expected %0d/51", n, cmd_reg, 9 + 512);
    end
    wait_sig(0, 50, n);
    tests++;
    if (n !== 9 || cmd_reg !== 8'h52) begin
      fails++; $display("FAIL delay_zero: got %0d reg=%h expected 9/52", n, cmd_reg);
    end
    wait_sig(1, 50, n);
    tests++;
    if (n !== 6 || log_reg.size() !== 3) begin
      fails++; $display("FAIL delay_done: got n=%0d cmds=%0d expected 6/3", n, log_reg.size());
    end
  endtask

  task automatic test_stray_and_busy_start();
    int n;
    clear_rom();
    rom[0] = 16'h6001; rom[1] = 16'h6102; rom[2] = 16'hFE00;
    start = 1;
    #1 stray_req = 1;
    @(negedge clk);
    start = 0;
    wait_sig(0, 50, n);
    tests++;
    if (n !== 2 || cmd_reg !== 8'h60 || rom_addr !== 5'd0) begin
      fails++; $display("FAIL stray_rsp: got n=%0d reg=%h addr=%0d expected 2/60/0", n, cmd_reg, rom_addr);
    end
    @(negedge clk);
    pulse_start();
    wait_sig(0, 50, n);
    tests++;
    if (n !== 4 || cmd_reg !== 8'h61 || rom_addr !== 5'd1) begin
      fails++; $display("FAIL busy_start: got n=%0d reg=%h expected 4/61", n, cmd_reg);
    end
    wait_sig(1, 50, n);
    tests++;
    if (n !== 6 || log_reg.size() !== 2) begin
      fails++; $display("FAIL stray_done: got n=%0d cmds=%0d expected 6/2", n, log_reg.size());
    end
  endtask

  task automatic test_table_len();
    int n;
    clear_rom();
    for (int i = 0; i < 8; i++) rom[i] = {8'h70 + 8'(i), 8'(i)};
    pulse_start();
    for (int i = 0; i < 8; i++) wait_sig(0, 50, n);
    tests++;
    if (cmd_reg !== 8'h77 || rom_addr !== 5'd7) begin
      fails++; $display("FAIL last_entry: got reg=%h addr=%0d expected 77/7", cmd_reg, rom_addr);
    end
    wait_sig(1, 50, n);
    tests++;
    if (n !== 4 || rom_addr !== 5'd7 || log_reg.size() !== 8) begin
      fails++; $display("FAIL table_end: got n=%0d addr=%0d cmds=%0d expected 4/7/8", n, rom_addr, log_reg.size());
    end
  endtask

  task automatic test_reset_mid_issue();
    int n;
    clear_rom();
    rom[0] = 16'h1234; rom[1] = 16'h5678; rom[2] = 16'hFE00;
    stall_cfg = 100;
    pulse_start();
    wait_sig(0, 50, n);
    @(negedge clk);
    #2 rst = 1;
    #1;
    tests++;
    if (cmd_valid !== 1'b0) begin fails++; $display("FAIL async_drop: got valid=%0b expected 0", cmd_valid); end
    tests++;
    if ({rom_addr, cmd_dev, cmd_reg, cmd_data, busy, done, error, err_index} !== '0) begin
      fails++; $display("FAIL reset_clear: got reg=%h busy=%0b done=%0b expected 0", cmd_reg, busy, done);
    end
    stall_cfg = 0;
    @(negedge clk);
    @(negedge clk);
    log_reg.delete(); log_data.delete(); log_dev.delete();
    rst = 0;
    wait_sig(0, 200, n);
    tests++;
    if (n !== P + 3 || cmd_reg !== 8'h12 || rom_addr !== 5'd0) begin
      fails++; $display("FAIL reset_rerun: got n=%0d reg=%h expected %0d/12", n, cmd_reg, P + 3);
    end
    wait_sig(1, 200, n);
    tests++;
    if (n < 0 || log_reg.size() !== 2) begin
      fails++; $display("FAIL reset_rerun_done: got n=%0d cmds=%0d expected done/2", n, log_reg.size());
    end
  endtask

  initial begin
    test_reset();
    test_ready_stall();
    test_nack_retry();
    test_nack_fail();
    test_delay();
    test_stray_and_busy_start();
    test_table_len();
    test_reset_mid_issue();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
